// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its entry FIFO.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode-handshake signals of the fetch stage.
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc_plus4;
    logic            misalign_err;

    modport master (
        output imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, misalign_err,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, misalign_err,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch-entry FIFO: write visible at head next cycle, head read combinationally.
// Writes when full only land if a read happens the same cycle; flush beats everything.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  fetch_entry_t             wr_data,
    input  logic                     rd_en,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_rd;
    logic            w_wr;

    assign w_rd = rd_en & (r_count != '0);
    assign w_wr = wr_en & ((r_count != CW'(DEPTH)) | w_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
endmodule

// File: rtl/fetch_stage.sv
// PC owner and fetch stage: entry reaches decode one cycle after its fetch, one per cycle.
// Stalls the PC when the FIFO is full and not draining; redirect flushes and wins over all.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic      clk,
    input  logic      rst,
    fetch_if.master   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] w_pc_next;
    logic            w_deq;
    logic            w_fetch;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wr_data;

    assign w_deq     = bus.out_valid & bus.out_ready;
    assign w_fetch   = ~bus.redirect_valid & ((w_count != CW'(DEPTH)) | w_deq);
    assign w_wr_data = '{pc: r_pc, instr: bus.imem_rdata};

    always_comb begin
        w_pc_next = r_pc;
        if (bus.redirect_valid) begin
            w_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_fetch) begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            // Sticky: only reset clears it; the redirect itself still proceeds.
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.redirect_valid),
        .wr_en   (w_fetch),
        .wr_data (w_wr_data),
        .rd_en   (w_deq),
        .rd_data (w_head),
        .count   (w_count)
    );

    assign bus.imem_addr    = r_pc;
    assign bus.out_valid    = (w_count != '0);
    assign bus.out_pc       = w_head.pc;
    assign bus.out_instr    = w_head.instr;
    assign bus.out_pc_plus4 = w_head.pc + PC_STEP;
    assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirect, misalign, wrap, async reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if bus_w ();

    // Memory model: word index offset by 0x1000_0000.
    assign bus.imem_rdata   = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};
    assign bus_w.imem_rdata = 32'h1000_0000 + {2'b00, bus_w.imem_addr[31:2]};

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.out_ready        = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        bus_w.out_ready      = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid",    32'(bus.out_valid),    32'd0);
        chk("rst_pc",       bus.out_pc,            32'h0);
        chk("rst_instr",    bus.out_instr,         32'h0);
        chk("rst_plus4",    bus.out_pc_plus4,      32'h4);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        chk("rst_addr",     bus.imem_addr,         32'h0);
        chk("rst_addr_w",   bus_w.imem_addr,       32'hFFFF_FFF8);

        // Streaming, plus wrap-around on the second instance
        rst = 1'b1;
        cyc();
        chk("str_valid", 32'(bus.out_valid), 32'd1);
        chk("str_pc0",   bus.out_pc,         32'h0);
        chk("str_ins0",  bus.out_instr,      32'h1000_0000);
        chk("str_p4_0",  bus.out_pc_plus4,   32'h4);
        chk("wrap_pc0",  bus_w.out_pc,       32'hFFFF_FFF8);
        chk("wrap_ins0", bus_w.out_instr,    32'h4FFF_FFFE);
        cyc();
        chk("wrap_pc1",  bus_w.out_pc,       32'hFFFF_FFFC);
        chk("wrap_p4_1", bus_w.out_pc_plus4, 32'h0);
        chk("wrap_ins1", bus_w.out_instr,    32'h4FFF_FFFF);
        chk("str_pc1",   bus.out_pc,         32'h4);
        cyc();
        chk("wrap_pc2",  bus_w.out_pc,       32'h0);
        chk("wrap_ins2", bus_w.out_instr,    32'h1000_0000);
        chk("str_pc2",   bus.out_pc,         32'h8);
        chk("str_ins2",  bus.out_instr,      32'h1000_0002);
        cyc();
        chk("str_pc3",   bus.out_pc,         32'hC);
        chk("str_ins3",  bus.out_instr,      32'h1000_0003);
        chk("str_p4_3",  bus.out_pc_plus4,   32'h10);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_addr",  bus.imem_addr,      32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("arst_pc0", bus.out_pc, 32'h0);
        cyc();
        chk("arst_pc1", bus.out_pc, 32'h4);

        // Backpressure from reset
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_pc",    bus.out_pc,         32'h0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("bp_count", 32'(u_dut.w_count), 32'd2);
        chk("bp_addr",  bus.imem_addr,      32'h8);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("bp_seq", bus.out_pc, 32'(4 * i));
        end

        // Redirect flush with FIFO full
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rd_full", 32'(u_dut.w_count), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("rd_valid0", 32'(bus.out_valid), 32'd0);
        chk("rd_addr",   bus.imem_addr,      32'h100);
        cyc();
        chk("rd_valid1", 32'(bus.out_valid), 32'd1);
        chk("rd_pc",     bus.out_pc,         32'h100);
        chk("rd_instr",  bus.out_instr,      32'h1000_0040);

        // Misaligned redirect, then aligned and back-to-back redirects
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("mis_addr",  bus.imem_addr,         32'h100);
        chk("mis_flag",  32'(bus.misalign_err), 32'd1);
        chk("mis_valid", 32'(bus.out_valid),    32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cyc();
        chk("mis_sticky", 32'(bus.misalign_err), 32'd1);
        chk("mis_addr2",  bus.imem_addr,         32'h200);
        bus.redirect_pc = 32'h300;
        cyc();
        bus.redirect_pc = 32'h400;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("cons_addr",  bus.imem_addr,      32'h400);
        chk("cons_valid", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("cons_pc",     bus.out_pc,            32'h400);
        chk("cons_instr",  bus.out_instr,         32'h1000_0100);
        chk("cons_sticky", 32'(bus.misalign_err), 32'd1);

        rst = 1'b0;
        #1;
        chk("mis_clear", 32'(bus.misalign_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and fetch stage directly upstream of the instruction memory.
- Owns the PC, drives the word-addressed memory address each cycle, and captures the combinational read data with its PC into a small FIFO.
- Presents {pc, instr, pc+4} to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DEPTH, 2, fetch FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- imem_addr  output  32  byte address to instruction memory; memory uses bits [31:2].
- imem_rdata  input  32  instruction word; combinational, same cycle as imem_addr.
- redirect_valid  input  1  load new PC this cycle.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately) sets:
  - pc = RESET_PC, FIFO count = 0, all entries = 0.
  - out_valid = 0, out_pc = 0, out_instr = 0, out_pc_plus4 = 4, misalign_err = 0, imem_addr = RESET_PC.
- imem_addr = pc (registered value, no combinational path from inputs).
- deq = out_valid & out_ready.
- fetch = ~redirect_valid & ((count != DEPTH) | deq).
- Fetch cycle (fetch=1):
  - Enqueue {pc, imem_rdata} at tail.
  - pc <= pc + 4; wraps 32'hFFFFFFFC -> 0.
- No fetch and no redirect: pc holds, imem_addr stable.
- Simultaneous enqueue and dequeue when full is legal; count is unchanged.
- Latency: entry appears at the head (out_valid=1) one cycle after its fetch cycle.
- Throughput: one instruction per cycle while out_ready=1.
- Handshake:
  - out_pc, out_instr and out_pc_plus4 remain stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a deq, a redirect, or a reset.
- Redirect has the highest priority:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO is flushed (count = 0, pointers reset), no enqueue that cycle.
  - A deq in the same cycle counts as a completed transfer of the old head.
  - Next cycle: out_valid = 0, imem_addr = target.
  - The cycle after that, the target entry is at the head.
- misalign_err: set when redirect_valid=1 and redirect_pc[1:0] != 0. It stays set until reset and does not block operation.
- out_valid = (count != 0).
- Head outputs read combinationally from the FIFO head slot.
- FIFO internals: read/write pointers of log2(DEPTH) bits, wrapping naturally; count of log2(DEPTH)+1 bits.
- Consecutive redirects: each redirect wins; only the last target survives.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32.
  - ILEN = 32.
  - PC_STEP = 4.
  - NOP_INSTR = 32'h00000013.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, parameterised by DEPTH.
  - Ports: clk, rst, flush, wr_en, wr_data, rd_en, rd_data, count.
  - Asynchronous active-low reset, matching this block.
- Top level contains the PC register, next-PC logic, error flag, and the fetch/deq decisions.

Test Plan:
- Streaming: imem model returns 32'h1000_0000 + word_index; release reset with out_ready=1.
  - out_valid rises one cycle after release.
  - out_pc = 0, 4, 8, C… one per cycle; out_instr = 1000_0000, 1000_0001…; out_pc_plus4 = out_pc + 4.
- Backpressure: out_ready=0 from reset for 5 cycles.
  - Count reaches 2 and imem_addr holds at 8.
  - out_pc holds at 0 and stays stable.
  - Raise out_ready: sequence 0, 4, 8, C with no gaps or duplicates.
- Redirect flush: with FIFO full (heads 0, 4), pulse redirect_valid with redirect_pc = 0x100.
  - Next cycle: out_valid = 0, imem_addr = 0x100.
  - Following cycle: out_pc = 0x100, out_instr = 1000_0040.
- Misaligned redirect: redirect_pc = 0x102.
  - imem_addr becomes 0x100 and misalign_err = 1.
  - The flag remains 1 across later aligned redirects until rst=0.
- Wrap-around: RESET_PC = 32'hFFFFFFF8 with out_ready=1.
  - out_pc = FFFFFFF8, FFFFFFFC, 00000000.
  - out_pc_plus4 of FFFFFFFC = 0.
- Asynchronous reset mid-stream: drop rst between clock edges while out_valid = 1.
  - out_valid = 0 and imem_addr = RESET_PC before the next edge.
  - After release, streaming restarts from RESET_PC.
